// File: rtl/ddr_wr_arb.sv
// Round-robin arbiter sharing the DDR write command/data port among CH_NUM channels.
// Define DDR_WR_ARB_WDT_EN to add a per-burst watchdog that aborts hung bursts.
module ddr_wr_arb #(
    parameter int CH_NUM     = 4,
    parameter int ADDR_WIDTH = 27,
    parameter int DQ_WIDTH   = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                             ddr_clk,
    input  logic                             ddr_rstn,
    input  logic [CH_NUM-1:0]                ch_wreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]     ch_waddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_wr_len,
    input  logic [CH_NUM*8*DQ_WIDTH-1:0]     ch_wdata,
    output logic [CH_NUM-1:0]                ch_wrdy,
    output logic [CH_NUM-1:0]                ch_wdata_req,
    output logic [CH_NUM-1:0]                ch_wdone,
    output logic                             ddr_wreq,
    output logic [ADDR_WIDTH-1:0]            ddr_waddr,
    output logic [LEN_WIDTH-1:0]             ddr_wr_len,
    input  logic                             ddr_wrdy,
    input  logic                             ddr_wdata_req,
    input  logic                             ddr_wdone,
    output logic [8*DQ_WIDTH-1:0]            ddr_wdata,
    output logic [2:0]                       grant_id,
    output logic                             wdt_err
);

    localparam int DW = 8 * DQ_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            last_id;
    logic [3:0]            start;
    logic [2*CH_NUM-1:0]   req_rot;
    logic                  pick_valid;
    logic [2:0]            pick_id;
    logic [CH_NUM-1:0]     gnt_oh;
    logic                  wdt_hit;

    // Rotate the request vector so bit 0 is the channel right after last_id;
    // the lowest set bit of the rotated vector is the winner.
    always_comb begin
        start      = {1'b0, last_id} + 4'd1;
        req_rot    = {ch_wreq, ch_wreq} >> start;
        pick_valid = 1'b0;
        pick_id    = 3'd0;
        for (int j = CH_NUM - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_valid = 1'b1;
                pick_id    = 3'((int'(start) + j) % CH_NUM);
            end
        end
    end

`ifdef DDR_WR_ARB_WDT_EN
    logic [15:0] wdt_cnt;
    logic        wdt_err_q;

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            wdt_cnt   <= 16'd0;
            wdt_err_q <= 1'b0;
        end else begin
            if (state == IDLE) wdt_cnt <= 16'd0;
            else               wdt_cnt <= wdt_cnt + 16'd1;
            if (wdt_hit) wdt_err_q <= 1'b1;
        end
    end

    assign wdt_hit = (state != IDLE) && (wdt_cnt == 16'(WDT_CYCLES - 1));
    assign wdt_err = wdt_err_q;
`else
    assign wdt_hit = 1'b0;
    assign wdt_err = 1'b0 && (WDT_CYCLES > 0);
`endif

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    // ddr_wreq is the valid and ddr_wrdy the ready of the command channel: the
    // command transfers in the cycle both are high, and ddr_wreq stays high with
    // stable address/length until then (only reset or the watchdog withdraw it).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = CMD;
            CMD:     if (wdt_hit) state_nxt = IDLE;
                     else if (ddr_wrdy) state_nxt = DATA;
            DATA:    if (wdt_hit || ddr_wdone) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            grant_id   <= 3'd0;
            last_id    <= 3'(CH_NUM - 1);
            ddr_waddr  <= '0;
            ddr_wr_len <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant_id   <= pick_id;
                ddr_waddr  <= ch_waddr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
                ddr_wr_len <= ch_wr_len[pick_id*LEN_WIDTH +: LEN_WIDTH];
            end
            if (state == CMD && (ddr_wrdy || wdt_hit)) last_id <= grant_id;
        end
    end

    always_comb begin
        gnt_oh       = {{(CH_NUM-1){1'b0}}, 1'b1} << grant_id;
        ddr_wreq     = (state == CMD);
        ch_wrdy      = '0;
        ch_wdata_req = '0;
        ch_wdone     = '0;
        if (state == CMD && ddr_wrdy && !wdt_hit)      ch_wrdy      = gnt_oh;
        if (state != IDLE && ddr_wdata_req)            ch_wdata_req = gnt_oh;
        if ((state == DATA && ddr_wdone) || wdt_hit)   ch_wdone     = gnt_oh;
    end

    assign ddr_wdata = ch_wdata[grant_id*DW +: DW];

endmodule

// File: doc/ddr_wr_arb.md
# ddr_wr_arb

Round-robin arbiter that shares the single DDR write-command/data port among up to CH_NUM line-buffer write channels, such as per-video-input frame writers. It sits between the write buffers and the DDR write controller, all in the ddr_clk domain. It grants one channel per burst and latches that channel's address and length. It steers the data-request/data path to the granted channel until ddr_wdone, then rotates priority.

## Interface
- CH_NUM, 4: number of requesting channels (2..8)
- ADDR_WIDTH, 27: DDR address width
- DQ_WIDTH, 32: DDR DQ width; data bus is 8*DQ_WIDTH
- LEN_WIDTH, 32: burst length field width
- WDT_CYCLES, 4096: watchdog limit in ddr_clk cycles (used only with DDR_WR_ARB_WDT_EN)

Ports:
- ddr_clk  in  1  sole clock
- ddr_rstn  in  1  asynchronous, active-low reset
- ch_wreq  in  CH_NUM  per-channel burst request, level, held until that channel's ch_wdata_req
- ch_waddr  in  CH_NUM*ADDR_WIDTH  packed burst addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wr_len  in  CH_NUM*LEN_WIDTH  packed burst lengths
- ch_wdata  in  CH_NUM*8*DQ_WIDTH  packed write data
- ch_wrdy  out  CH_NUM  command-accept strobe to the granted channel
- ch_wdata_req  out  CH_NUM  data request to the granted channel
- ch_wdone  out  CH_NUM  burst-complete strobe to the granted channel
- ddr_wreq  out  1  command request to the controller
- ddr_waddr  out  ADDR_WIDTH  latched address
- ddr_wr_len  out  LEN_WIDTH  latched length
- ddr_wrdy  in  1  controller accepts the command (ddr_wreq & ddr_wrdy)
- ddr_wdata_req  in  1  controller data request
- ddr_wdone  in  1  controller burst complete
- ddr_wdata  out  8*DQ_WIDTH  data of the granted channel
- grant_id  out  3  index of the current or last grant
- wdt_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, CMD, DATA.
- IDLE:
  - If any ch_wreq is high, select the first requester after last_id (cyclic order last_id+1, last_id+2, ...).
  - Register grant_id, ddr_waddr and ddr_wr_len from that channel; go to CMD.
- CMD:
  - ddr_wreq=1.
  - On ddr_wrdy: pulse ch_wrdy[grant_id] (combinational passthrough), set last_id=grant_id, go to DATA.
- DATA:
  - ddr_wreq=0.
  - ch_wdata_req[grant_id] = ddr_wdata_req (combinational).
  - On ddr_wdone: ch_wdone[grant_id] = 1 for that cycle; go to IDLE.
- Data routing:
  - ddr_wdata = ch_wdata slice for grant_id in every state (combinational mux).
  - ch_wdata_req is also routed in CMD, so a controller that raises ddr_wdata_req in the ddr_wrdy cycle is served.
- Strobe gating: non-granted channels see 0 on ch_wrdy, ch_wdata_req and ch_wdone.
- Ignored inputs: ddr_wdone in IDLE/CMD and ddr_wdata_req in IDLE are ignored (no strobes issued).
- Request changes: changes on ch_wreq of non-granted channels never affect the current burst. A granted channel dropping ch_wreq during CMD does not cancel the command.
- Reset mid-burst: the asynchronous ddr_rstn assertion forces IDLE immediately. All strobes drop combinationally with the state.

## Timing
- Reset values:
  - ddr_wreq=0, ddr_waddr=0, ddr_wr_len=0, grant_id=0, wdt_err=0.
  - All ch_* outputs are 0.
  - last_id=CH_NUM-1, so channel 0 wins first.
- Request latency: ch_wreq sampled high at edge N in IDLE gives ddr_wreq=1 and a valid address from edge N+1.
- Back-to-back bursts: ddr_wdone at edge M returns to IDLE; the next ddr_wreq can rise at edge M+2 (one idle arbitration cycle).
- Fairness: a continuously requesting channel waits at most CH_NUM-1 bursts.
- Latched fields: ddr_waddr and ddr_wr_len stay stable from CMD entry until the next IDLE grant.

## Configuration
- DDR_WR_ARB_WDT_EN defined:
  - A 16-bit counter clears on entering CMD and increments in CMD/DATA.
  - When it reaches WDT_CYCLES: set wdt_err (sticky until reset), pulse ch_wdone[grant_id], return to IDLE.
- Not defined: no counter; wdt_err is tied 0; the FSM waits indefinitely.

## Test plan
- Reset, then ch_wreq=4'b0001 with addr 0x100 and len 40 -> ddr_wreq at the next edge, ddr_waddr=0x100, ddr_wr_len=40; ddr_wrdy gives ch_wrdy=0001; ddr_wdone gives ch_wdone=0001 and IDLE.
- All four ch_wreq held high for 8 bursts -> grant order 0,1,2,3,0,1,2,3, with one IDLE cycle between bursts.
- During a DATA burst for channel 2, pulse ddr_wdata_req 40 times -> exactly 40 ch_wdata_req[2] pulses, 0 on other channels; ddr_wdata equals ch_wdata slice 2 every cycle.
- Assert ddr_rstn low mid-DATA -> ddr_wreq, ch_* and grant_id become 0 without a clock edge; after release, channel 0 has priority.
- With DDR_WR_ARB_WDT_EN and WDT_CYCLES=64, withhold ddr_wdone -> wdt_err=1 and a ch_wdone pulse at cycle 64, then the next request is granted; without the macro, the FSM stays in DATA and wdt_err=0.
